// File: rtl/comms_debug_pkg.sv
// Shared types for the CommsFPGA debug probe capture unit.
package comms_debug_pkg;

    // Capture sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRETRIG   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POSTTRIG  = 3'd3,
        ST_DONE      = 3'd4
    } capture_state_e;

    // Trigger mode encodings for trig_edge
    localparam logic TRIG_LEVEL = 1'b0;
    localparam logic TRIG_EDGE  = 1'b1;

endpackage

// File: rtl/comms_debug_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module comms_debug_sample_ram #(
    parameter int DEPTH  = 256,
    parameter int W      = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/comms_debug_probe_capture.sv
// Debug capture unit: channel select, masked level/edge trigger and a
// pre/post-trigger window held in a circular sample buffer.
// The state output is a debug view of the capture sequencer.
module comms_debug_probe_capture
    import comms_debug_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CH_W   = 16,
    parameter int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                   clk16x,
    input  logic                   reset,
    input  logic [NUM_CH*CH_W-1:0] probe_bus,
    input  logic                   sample_en,
    input  logic [SEL_W-1:0]       ch_sel,
    input  logic [CH_W-1:0]        trig_value,
    input  logic [CH_W-1:0]        trig_mask,
    input  logic                   trig_edge,
    input  logic [ADDR_W-1:0]      pretrig_len,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [CH_W-1:0]        rd_data,
    output logic                   armed,
    output logic                   triggered,
    output logic                   done,
    output logic [ADDR_W-1:0]      trig_ptr,
    output capture_state_e         state
);

    capture_state_e    state_q, state_d;
    logic [SEL_W-1:0]  ch_q;
    logic [CH_W-1:0]   value_q, mask_q;
    logic              edge_q;
    logic [ADDR_W-1:0] pre_len_q, pre_clamp, post_len;
    logic [ADDR_W-1:0] cnt_q, cnt_inc;
    logic [ADDR_W-1:0] wr_ptr_q, trig_ptr_q, rd_phys;
    logic              match_prev_q, rd_valid_q;
    logic [CH_W-1:0]   sel_data, ram_q;
    logic              match, capturing, sample, eval_trig, fire;

    // Channel multiplexer on the latched channel index
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == SEL_W'(k)) begin
                sel_data = probe_bus[k*CH_W +: CH_W];
            end
        end
    end

    // Trigger qualification and sample strobe
    always_comb begin
        pre_clamp = (pretrig_len > ADDR_W'(DEPTH-2)) ? ADDR_W'(DEPTH-2) : pretrig_len;
        post_len  = ADDR_W'(DEPTH-1) - pre_len_q;
        cnt_inc   = cnt_q + ADDR_W'(1);
        match     = ((sel_data ^ value_q) & mask_q) == '0;
        capturing = (state_q == ST_PRETRIG) || (state_q == ST_WAIT_TRIG) ||
                    (state_q == ST_POSTTRIG);
        // arm/abort cycles take no sample so the new configuration starts clean
        sample    = capturing && sample_en && !arm && !abort;
        // A zero-length pre-trigger lets the first PRETRIG sample evaluate the trigger
        eval_trig = sample && ((state_q == ST_WAIT_TRIG) ||
                               ((state_q == ST_PRETRIG) && (cnt_q == pre_len_q)));
        fire      = eval_trig && ((edge_q == TRIG_EDGE) ? (match && !match_prev_q) : match);
    end

    // Next-state logic; abort has priority over arm
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else if (arm) begin
            state_d = ST_PRETRIG;
        end else begin
            case (state_q)
                ST_PRETRIG: begin
                    if (fire) begin
                        state_d = ST_POSTTRIG;
                    end else if (sample && ((cnt_q == pre_len_q) || (cnt_inc == pre_len_q))) begin
                        state_d = ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (fire) begin
                        state_d = ST_POSTTRIG;
                    end
                end
                ST_POSTTRIG: begin
                    if (sample && (cnt_inc == post_len)) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State, configuration, pointers and edge history
    always_ff @(posedge clk16x) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            value_q      <= '0;
            mask_q       <= '0;
            edge_q       <= TRIG_LEVEL;
            pre_len_q    <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            trig_ptr_q   <= '0;
            match_prev_q <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= (state_q == ST_DONE);
            if (abort) begin
                cnt_q        <= '0;
                match_prev_q <= 1'b0;
                trig_ptr_q   <= '0;
            end else if (arm) begin
                ch_q         <= ch_sel;
                value_q      <= trig_value;
                mask_q       <= trig_mask;
                edge_q       <= trig_edge;
                pre_len_q    <= pre_clamp;
                cnt_q        <= '0;
                match_prev_q <= 1'b0;
                trig_ptr_q   <= '0;
            end else if (sample) begin
                wr_ptr_q     <= wr_ptr_q + ADDR_W'(1);
                match_prev_q <= match;
                cnt_q        <= (state_d != state_q) ? '0 : cnt_inc;
                if (fire) begin
                    trig_ptr_q <= wr_ptr_q;
                end
            end
        end
    end

    // Readout address: logical offset 0 is the oldest sample of the window
    always_comb begin
        rd_phys = trig_ptr_q - pre_len_q + rd_addr;
    end

    comms_debug_sample_ram #(
        .DEPTH  (DEPTH),
        .W      (CH_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk16x),
        .we    (sample),
        .waddr (wr_ptr_q),
        .wdata (sel_data),
        .raddr (rd_phys),
        .rdata (ram_q)
    );

    // Status outputs decoded from the registered state
    always_comb begin
        armed     = (state_q == ST_PRETRIG) || (state_q == ST_WAIT_TRIG);
        triggered = (state_q == ST_POSTTRIG) || (state_q == ST_DONE);
        done      = (state_q == ST_DONE);
        trig_ptr  = trig_ptr_q;
        state     = state_q;
        rd_data   = rd_valid_q ? ram_q : '0;
    end

endmodule
